popcount_acc_stream: RTL

//  Streaming, pipelined successor to the fixed 23-input combinational popcount.
//  - Counts set bits of an N_IN-wide input beat.
//  - Accumulates the counts over a multi-beat group delimited by in_last, so a neuron can have more inputs than N_IN.
//  - Compares the group total against a threshold to give a binary/ternary neuron activation.
//  - Optional runtime approximate mode truncates LSBs of each per-beat count.
//  - Sits between the sensor input registers and the neuron output stage; valid/ready on both sides.

---
 rtl/popcount_acc_stream.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/popcount_acc_stream.sv
// Streaming popcount neuron: counts set bits per beat, accumulates a group
// delimited by in_last and compares the saturated total against a threshold.
module popcount_acc_stream #(
    parameter int N_IN     = 23,
    parameter int PIPE     = 1,
    parameter int ACC_W    = 8,
    parameter int DROP_LSB = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    input  logic             in_last,
    input  logic             approx_en,
    input  logic [ACC_W-1:0] thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_fire,
    output logic             out_sat
);
    localparam int PC_W  = $clog2(N_IN + 1);
    localparam int HALF  = N_IN / 2;
    localparam int SUM_W = ((ACC_W > PC_W) ? ACC_W : PC_W) + 1;
    localparam logic [PC_W-1:0]  KEEP_MASK = {PC_W{1'b1}} << DROP_LSB;
    localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};

    function automatic logic [PC_W-1:0] count_range(input logic [N_IN-1:0] d,
                                                     input int lo, input int hi);
        logic [PC_W-1:0] c;
        c = {PC_W{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            c = c + (((i >= lo) && (i < hi)) ? PC_W'(d[i]) : {PC_W{1'b0}});
        end
        return c;
    endfunction

    logic             adv;
    logic             take;
    logic             s1_valid, s1_approx, s1_last;
    logic [PC_W-1:0]  s1_lo, s1_hi, s1_pc;
    logic [ACC_W-1:0] s1_thresh;
    logic             s2_valid, s2_approx, s2_last;
    logic [PC_W-1:0]  s2_pc;
    logic [ACC_W-1:0] s2_thresh;

    logic [ACC_W-1:0] acc;
    logic             first;
    logic             sat_flag;
    logic [PC_W-1:0]  pc_eff;
    logic [ACC_W-1:0] base;
    logic [SUM_W-1:0] sum_ext;
    logic             ovf;
    logic [ACC_W-1:0] sum_sat;
    logic             sat_next;

    // The pipe only moves when the output register can take a new result.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv && rst_n;
    assign take     = in_valid && in_ready;

    generate
        if (PIPE >= 1) begin : g_s1_reg
            // First tree stage: half-width partial counts plus beat sideband.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid  <= 1'b0;
                    s1_approx <= 1'b0;
                    s1_last   <= 1'b0;
                    s1_lo     <= {PC_W{1'b0}};
                    s1_hi     <= {PC_W{1'b0}};
                    s1_thresh <= {ACC_W{1'b0}};
                end else if (adv) begin
                    s1_valid  <= take;
                    s1_approx <= approx_en;
                    s1_last   <= in_last;
                    s1_lo     <= count_range(in_data, 0, HALF);
                    s1_hi     <= count_range(in_data, HALF, N_IN);
                    s1_thresh <= thresh;
                end
            end
        end else begin : g_s1_comb
            assign s1_valid  = take;
            assign s1_approx = approx_en;
            assign s1_last   = in_last;
            assign s1_lo     = count_range(in_data, 0, HALF);
            assign s1_hi     = count_range(in_data, HALF, N_IN);
            assign s1_thresh = thresh;
        end
    endgenerate

    assign s1_pc = s1_lo + s1_hi;

    generate
        if (PIPE >= 2) begin : g_s2_reg
            // Second tree stage: registered full per-beat count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid  <= 1'b0;
                    s2_approx <= 1'b0;
                    s2_last   <= 1'b0;
                    s2_pc     <= {PC_W{1'b0}};
                    s2_thresh <= {ACC_W{1'b0}};
                end else if (adv) begin
                    s2_valid  <= s1_valid;
                    s2_approx <= s1_approx;
                    s2_last   <= s1_last;
                    s2_pc     <= s1_pc;
                    s2_thresh <= s1_thresh;
                end
            end
        end else begin : g_s2_comb
            assign s2_valid  = s1_valid;
            assign s2_approx = s1_approx;
            assign s2_last   = s1_last;
            assign s2_pc     = s1_pc;
            assign s2_thresh = s1_thresh;
        end
    endgenerate

    // Saturating group sum; the first beat ignores whatever acc holds.
    always_comb begin
        pc_eff   = s2_approx ? (s2_pc & KEEP_MASK) : s2_pc;
        base     = first ? {ACC_W{1'b0}} : acc;
        sum_ext  = SUM_W'(base) + SUM_W'(pc_eff);
        ovf      = sum_ext > SUM_W'(ACC_MAX);
        sum_sat  = ovf ? ACC_MAX : sum_ext[ACC_W-1:0];
        sat_next = (first ? 1'b0 : sat_flag) | ovf;
    end

    // Accumulator and output register; last beat loads the result and rearms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= {ACC_W{1'b0}};
            first     <= 1'b1;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_count <= {ACC_W{1'b0}};
            out_fire  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            if (s2_valid && s2_last) begin
                out_count <= sum_sat;
                out_fire  <= (sum_sat >= s2_thresh);
                out_sat   <= sat_next;
                out_valid <= 1'b1;
                acc       <= {ACC_W{1'b0}};
                sat_flag  <= 1'b0;
                first     <= 1'b1;
            end else if (s2_valid) begin
                acc       <= sum_sat;
                sat_flag  <= sat_next;
                first     <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
